// File: rtl/sprite_fetch_sched_pkg.sv
// Shared types and register map for the per-frame sprite fetch scheduler.
// Holds the FSM state type, register addresses, field offsets and sprite field width.
package sprite_fetch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK   = 2'd1,
    ST_FETCH  = 2'd2,
    ST_COMMIT = 2'd3
  } fetch_state_t;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int SPR_W  = 8;
  localparam int SEL_W  = 3;

  // PacMan sits at 0; ghosts follow at 8 with a 6-register stride.
  localparam int PACMAN_BASE   = 0;
  localparam int GHOST_BASE    = 8;
  localparam int GHOST_STRIDE  = 6;
  localparam int LOCK_ADDR_DEF = 32;

  localparam logic [1:0] FLD_X   = 2'd0;
  localparam logic [1:0] FLD_Y   = 2'd1;
  localparam logic [1:0] FLD_ROT = 2'd2;

  function automatic logic [ADDR_W-1:0] sprite_base(input logic [SEL_W-1:0] s);
    int b;
    if (s == '0) b = PACMAN_BASE;
    else         b = GHOST_BASE + GHOST_STRIDE * (int'(s) - 1);
    return b[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_fetch_sched_shadow_buf.sv
// Staging + committed shadow storage for sprite x/y/rot, with atomic commit
// and a renderer-side select mux.
module sprite_shadow_buf
  import sprite_fetch_sched_pkg::*;
#(
  parameter int NUM_SPRITES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stg_we,
  input  logic [SEL_W-1:0] stg_sprite,
  input  logic [1:0]       stg_field,
  input  logic [SPR_W-1:0] stg_data,
  input  logic             commit,
  input  logic [SEL_W-1:0] spr_sel,
  output logic [SPR_W-1:0] spr_x,
  output logic [SPR_W-1:0] spr_y,
  output logic [SPR_W-1:0] spr_rot
);

  logic [SPR_W-1:0] stg_x [NUM_SPRITES];
  logic [SPR_W-1:0] stg_y [NUM_SPRITES];
  logic [SPR_W-1:0] stg_r [NUM_SPRITES];
  logic [SPR_W-1:0] shd_x [NUM_SPRITES];
  logic [SPR_W-1:0] shd_y [NUM_SPRITES];
  logic [SPR_W-1:0] shd_r [NUM_SPRITES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        stg_x[i] <= '0;
        stg_y[i] <= '0;
        stg_r[i] <= '0;
        shd_x[i] <= '0;
        shd_y[i] <= '0;
        shd_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (stg_we && stg_sprite == SEL_W'(i)) begin
          case (stg_field)
            FLD_X:   stg_x[i] <= stg_data;
            FLD_Y:   stg_y[i] <= stg_data;
            FLD_ROT: stg_r[i] <= stg_data;
            default: ;
          endcase
        end
        // The shadow only ever changes here, so the renderer never sees a half-fetched frame.
        if (commit) begin
          shd_x[i] <= stg_x[i];
          shd_y[i] <= stg_y[i];
          shd_r[i] <= stg_r[i];
        end
      end
    end
  end

  always_comb begin
    spr_x   = '0;
    spr_y   = '0;
    spr_rot = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (spr_sel == SEL_W'(i)) begin
        spr_x   = shd_x[i];
        spr_y   = shd_y[i];
        spr_rot = shd_r[i];
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_sched.sv
// Per-frame sprite fetch scheduler: on vsync, checks the frame lock, reads every
// sprite's x/y/rot from the register file and commits them atomically to a shadow.
module sprite_fetch_sched
  import sprite_fetch_sched_pkg::*;
#(
  parameter int NUM_SPRITES = 5,
  parameter int LOCK_ADDR   = LOCK_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync_start,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_in,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_out,
  input  logic [SEL_W-1:0]  spr_sel,
  output logic [SPR_W-1:0]  spr_x,
  output logic [SPR_W-1:0]  spr_y,
  output logic [SPR_W-1:0]  spr_rot,
  output logic              frame_done,
  output logic              frame_skip,
  output logic              overrun
);

  // CPU handshake: cpu_req is held until cpu_gnt; a grant performs the access
  // in that cycle, and a granted read returns data with cpu_rvalid one cycle later.

  localparam logic [SEL_W-1:0]  LAST_SPR = SEL_W'(NUM_SPRITES - 1);
  localparam logic [ADDR_W-1:0] LOCK_A   = ADDR_W'(LOCK_ADDR);

  fetch_state_t     state;
  logic             frame_pend;
  logic [SEL_W-1:0] fetch_spr;
  logic [1:0]       fetch_fld;
  logic             lock_busy;

  assign lock_busy  = (reg_out[SPR_W-1:0] != '0);
  assign cpu_gnt    = cpu_req && (state == ST_IDLE) && !frame_pend;
  assign frame_skip = (state == ST_LOCK) && lock_busy;

  // Fetcher owns the bus whenever it is addressing; the CPU only ever sees idle cycles.
  always_comb begin
    reg_addr = '0;
    reg_in   = '0;
    reg_we   = 1'b0;
    if (state == ST_LOCK) begin
      reg_addr = LOCK_A;
    end else if (state == ST_FETCH) begin
      reg_addr = sprite_base(fetch_spr) + {{(ADDR_W-2){1'b0}}, fetch_fld};
    end else if (cpu_gnt) begin
      reg_addr = cpu_addr;
      reg_in   = cpu_wdata;
      reg_we   = cpu_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      frame_pend <= 1'b0;
      overrun    <= 1'b0;
      fetch_spr  <= '0;
      fetch_fld  <= '0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= reg_out;

      if (vsync_start) begin
        if (state == ST_IDLE && !frame_pend) frame_pend <= 1'b1;
        else                                 overrun    <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_pend) begin
            state      <= ST_LOCK;
            frame_pend <= 1'b0;
          end
        end
        ST_LOCK: begin
          fetch_spr <= '0;
          fetch_fld <= '0;
          state     <= lock_busy ? ST_IDLE : ST_FETCH;
        end
        ST_FETCH: begin
          if (fetch_fld == FLD_ROT) begin
            fetch_fld <= FLD_X;
            if (fetch_spr == LAST_SPR) begin
              state      <= ST_COMMIT;
              frame_done <= 1'b1;
            end else begin
              fetch_spr <= fetch_spr + 1'b1;
            end
          end else begin
            fetch_fld <= fetch_fld + 1'b1;
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  sprite_shadow_buf #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_shadow_buf (
    .clk        (clk),
    .reset      (reset),
    .stg_we     (state == ST_FETCH),
    .stg_sprite (fetch_spr),
    .stg_field  (fetch_fld),
    .stg_data   (reg_out[SPR_W-1:0]),
    .commit     (state == ST_COMMIT),
    .spr_sel    (spr_sel),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_rot    (spr_rot)
  );

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Bench for sprite_fetch_sched: register-file model, frame-timeline reference model
// checked every cycle, plus directed scenarios with hand-computed literals.
module tb_sprite_fetch_sched;

  localparam int NSPR  = 5;
  localparam int LOCKA = 32;
  localparam int T_COMMIT = 3 * NSPR + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vsync_start = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [5:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [2:0]  spr_sel = '0;
  logic        cpu_gnt, cpu_rvalid, reg_we, frame_done, frame_skip, overrun;
  logic [15:0] cpu_rdata, reg_in, reg_out;
  logic [5:0]  reg_addr;
  logic [7:0]  spr_x, spr_y, spr_rot;

  sprite_fetch_sched dut (
    .clk(clk), .reset(reset), .vsync_start(vsync_start),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .reg_addr(reg_addr), .reg_in(reg_in), .reg_we(reg_we), .reg_out(reg_out),
    .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_rot(spr_rot),
    .frame_done(frame_done), .frame_skip(frame_skip), .overrun(overrun)
  );

  // ---------------- clock / register file ----------------
  always #5 clk = ~clk;

  logic [15:0] regs [64] = '{default: 16'h0};
  assign reg_out = regs[reg_addr];
  always @(posedge clk) if (reg_we) regs[reg_addr] <= reg_in;

  // ---------------- check helper ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int fld_addr(input int s, input int f);
    return (s == 0 ? 0 : 8 + 6 * (s - 1)) + f;
  endfunction

  // ---------------- reference model: frame timeline ----------------
  // m_t is the cycle number inside the current frame (1 = pending, 2 = lock, T_COMMIT = commit).
  bit          m_act, m_was, m_gnt, m_rv, m_ovr;
  int          m_t;
  logic [7:0]  m_x [8], m_y [8], m_r [8];
  logic [15:0] exp_q [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act = 0; m_t = 0; m_ovr = 0; m_rv = 0;
      for (int i = 0; i < 8; i++) begin m_x[i] = 0; m_y[i] = 0; m_r[i] = 0; end
      exp_q.delete();
    end else begin
      m_was = m_act;
      m_gnt = cpu_req && !m_was;
      m_rv  = m_gnt && !cpu_we;
      if (m_rv) exp_q.push_back(regs[cpu_addr]);
      if (m_was) begin
        if (m_t == 2 && regs[LOCKA][7:0] != 0) m_act = 0;
        else if (m_t == T_COMMIT) begin
          for (int s = 0; s < NSPR; s++) begin
            m_x[s] = regs[fld_addr(s, 0)][7:0];
            m_y[s] = regs[fld_addr(s, 1)][7:0];
            m_r[s] = regs[fld_addr(s, 2)][7:0];
          end
          m_act = 0;
        end else m_t++;
      end
      if (vsync_start) begin
        if (m_was) m_ovr = 1;
        else begin m_act = 1; m_t = 1; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       e_gnt;
  logic [5:0] e_addr;
  int         e_j;

  always @(negedge clk) begin
    if (reset) begin
      e_gnt  = cpu_req && !m_act;
      e_addr = '0;
      if (m_act && m_t == 2) e_addr = 6'(LOCKA);
      else if (m_act && m_t >= 3 && m_t <= T_COMMIT - 1) begin
        e_j = m_t - 3;
        e_addr = 6'(fld_addr(e_j / 3, e_j % 3));
      end else if (e_gnt) e_addr = cpu_addr;
      chk("cpu_gnt", cpu_gnt, e_gnt);
      chk("reg_addr", reg_addr, e_addr);
      chk("reg_we", reg_we, e_gnt && cpu_we);
      chk("reg_in", reg_in, e_gnt ? cpu_wdata : 16'h0);
      chk("frame_skip", frame_skip, m_act && m_t == 2 && regs[LOCKA][7:0] != 0);
      chk("frame_done", frame_done, m_act && m_t == T_COMMIT);
      chk("overrun", overrun, m_ovr);
      chk("cpu_rvalid", cpu_rvalid, m_rv);
      if (m_rv) begin
        if (exp_q.size() == 0) chk("rdata_q_size", 32'(exp_q.size()), 1);
        else chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
      end
      chk("spr_x", spr_x, m_x[spr_sel]);
      chk("spr_y", spr_y, m_y[spr_sel]);
      chk("spr_rot", spr_rot, m_r[spr_sel]);
    end
  end

  // ---------------- drivers (all start and end 1 time unit after posedge) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [15:0] d);
    int k;
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
    #1;
    k = 0;
    while (!cpu_gnt && k < 100) begin tick(); #1; k++; end
    if (!cpu_gnt) chk("cpu_write_gnt_timeout", cpu_gnt, 1);
    @(posedge clk); #1;
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic pulse_vsync();
    vsync_start = 1;
    tick();
    vsync_start = 0;
  endtask

  // Called in cycle 1 of a frame; records cycle numbers of frame_done / frame_skip.
  task automatic watch(input int ncyc, input int pulse_at, input int rst_at,
                       output int done_cyc, output int done_cnt, output int skip_cyc);
    done_cyc = 0; done_cnt = 0; skip_cyc = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == pulse_at) vsync_start = 1;
      if (k == rst_at) reset = 0;
      #1;
      if (frame_done) begin done_cnt++; if (done_cyc == 0) done_cyc = k; end
      if (frame_skip && skip_cyc == 0) skip_cyc = k;
      tick();
      vsync_start = 0;
    end
  endtask

  int pa [16] = '{0, 1, 2, 8, 9, 10, 14, 15, 16, 20, 21, 22, 26, 27, 28, 32};
  int pd [16] = '{10, 20, 1, 30, 40, 2, 50, 60, 3, 70, 80, 4, 90, 100, 5, 0};
  int dc, dn, sc, gk, rk;
  logic [15:0] rd;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1;
    #1;
    chk("reset_overrun", overrun, 0);
    chk("reset_spr_x", spr_x, 0);
    chk("reset_rvalid", cpu_rvalid, 0);
    chk("reset_frame_done", frame_done, 0);
    tick();

    // CPU write while idle: one-cycle register write, no read-valid
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'd20; cpu_wdata = 16'h00AB;
    #1;
    chk("wr_gnt", cpu_gnt, 1);
    chk("wr_reg_we", reg_we, 1);
    chk("wr_reg_in", reg_in, 16'h00AB);
    chk("wr_reg_addr", reg_addr, 20);
    tick();
    cpu_req = 0; cpu_we = 0;
    #1;
    chk("wr_reg_we_drop", reg_we, 0);
    chk("wr_rvalid", cpu_rvalid, 0);
    chk("wr_regfile", regs[20], 16'h00AB);
    tick();

    for (int i = 0; i < 16; i++) cpu_write(6'(pa[i]), 16'(pd[i]));

    // Normal frame
    spr_sel = 3'd1;
    pulse_vsync();
    watch(22, 0, 0, dc, dn, sc);
    chk("f1_done_cycle", dc, 18);
    chk("f1_done_count", dn, 1);
    chk("f1_no_skip", sc, 0);
    spr_sel = 3'd0; #1;
    chk("f1_s0_x", spr_x, 10); chk("f1_s0_y", spr_y, 20); chk("f1_s0_rot", spr_rot, 1);
    spr_sel = 3'd1; #1;
    chk("f1_s1_x", spr_x, 30); chk("f1_s1_y", spr_y, 40); chk("f1_s1_rot", spr_rot, 2);
    spr_sel = 3'd4; #1;
    chk("f1_s4_x", spr_x, 90);
    spr_sel = 3'd5; #1;
    chk("f1_sel_oob", {spr_x, spr_y, spr_rot}, 0);
    tick();

    // Locked frame is skipped, shadow keeps old values
    cpu_write(6'(LOCKA), 16'h0001);
    cpu_write(6'd0, 16'd99);
    spr_sel = 3'd0;
    pulse_vsync();
    watch(6, 0, 0, dc, dn, sc);
    chk("lock_skip_cycle", sc, 2);
    chk("lock_no_done", dn, 0);
    chk("lock_shadow_x", spr_x, 10);
    cpu_write(6'(LOCKA), 16'h0000);

    // CPU read held during a fetch
    pulse_vsync();
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd9;
    gk = 0; rk = 0; rd = '0;
    for (int k = 1; k <= 25; k++) begin
      #1;
      if (cpu_gnt && gk == 0) gk = k;
      if (cpu_rvalid && rk == 0) begin rk = k; rd = cpu_rdata; end
      tick();
      if (gk != 0) cpu_req = 0;
    end
    chk("rd_gnt_cycle", gk, 19);
    chk("rd_rvalid_cycle", rk, 20);
    chk("rd_data", rd, 40);
    chk("rd_new_s0_x", spr_x, 99);

    // Second vsync while busy
    chk("ovr_before", overrun, 0);
    pulse_vsync();
    watch(22, 10, 0, dc, dn, sc);
    chk("ovr_set", overrun, 1);
    chk("ovr_done_count", dn, 1);
    chk("ovr_done_cycle", dc, 18);
    repeat (5) tick();
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of a fetch
    spr_sel = 3'd1;
    pulse_vsync();
    watch(12, 0, 8, dc, dn, sc);
    chk("rst_no_done", dn, 0);
    chk("rst_shadow_x", spr_x, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1;
    repeat (3) tick();
    chk("rst_after_x", spr_x, 0);
    chk("rst_after_done", frame_done, 0);

    chk("rdata_q_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
